// File: rtl/ift_pkg.sv
// ============================================================================
// ift_pkg : shared taint types and the gate-level AND taint rule
// Rev 1.0
// ============================================================================
`default_nettype none

package ift_pkg;

  localparam int TW_DEFAULT = 32;

  typedef logic [TW_DEFAULT-1:0] taint_t;

  // A label survives unless an untainted controlling 0 on the other input masks it.
  function automatic taint_t and_taint(input logic a, input taint_t a_t,
                                       input logic b, input taint_t b_t);
    return ({TW_DEFAULT{b}} & a_t) | ({TW_DEFAULT{a}} & b_t) | (a_t & b_t);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hierarchy_cell.sv
// ============================================================================
// hierarchy_cell : combinational AND with precise taint propagation
// Rev 1.0
// ============================================================================
`default_nettype none

module hierarchy_cell
  import ift_pkg::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic          a,
  input  logic [TW-1:0] a_t,
  input  logic          b,
  input  logic [TW-1:0] b_t,
  output logic          y,
  output logic [TW-1:0] y_t
);

  assign y = a & b;

  generate
    if (TW == TW_DEFAULT) begin : g_pkg_rule
      assign y_t = and_taint(a, a_t, b, b_t);
    end else begin : g_generic_rule
      assign y_t = ({TW{b}} & a_t) | ({TW{a}} & b_t) | (a_t & b_t);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hierarchy.sv
// ============================================================================
// hierarchy : registered AND of a and b with its taint label, via one sub-cell
// Rev 1.0
// ============================================================================
`default_nettype none

module hierarchy
  import ift_pkg::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a,
  input  logic [TW-1:0] a_t,
  input  logic          b,
  input  logic [TW-1:0] b_t,
  output logic          c,
  output logic [TW-1:0] c_t
);

  logic          y;
  logic [TW-1:0] y_t;

  // Taint must cross this instance boundary; do not flatten the cell.
  hierarchy_cell #(
    .TW (TW)
  ) u_cell (
    .a   (a),
    .a_t (a_t),
    .b   (b),
    .b_t (b_t),
    .y   (y),
    .y_t (y_t)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c   <= 1'b0;
      c_t <= '0;
    end else begin
      c   <= y;
      c_t <= y_t;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hierarchy.sv
// Self-checking bench for hierarchy: directed literal cases plus randomized stream
// compared against a flip-enumeration taint model.
`default_nettype none

module tb_hierarchy;

  logic        clk;
  logic        rst_n;
  logic        a, b;
  logic [31:0] a_t, b_t;
  logic        c;
  logic [31:0] c_t;

  int checks = 0;
  int errors = 0;

  logic        exp_c;
  logic [31:0] exp_ct;
  logic        model_on = 1'b0;

  hierarchy #(.TW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .a_t   (a_t),
    .b     (b),
    .b_t   (b_t),
    .c     (c),
    .c_t   (c_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Label k taints the output iff altering the inputs carrying label k can change a&b.
  function automatic logic [31:0] ref_taint(logic va, logic [31:0] vat, logic vb, logic [31:0] vbt);
    logic [31:0] r;
    logic        base;
    r    = '0;
    base = va & vb;
    for (int k = 0; k < 32; k++) begin
      for (int xa = 0; xa < 2; xa++) begin
        for (int xb = 0; xb < 2; xb++) begin
          logic ca, cb;
          ca = xa[0];
          cb = xb[0];
          if ((ca == va || vat[k]) && (cb == vb || vbt[k]) && ((ca & cb) != base))
            r[k] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got c=%b c_t=%h, expected c=%b c_t=%h",
               name, act[32], act[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Scoreboard: expected register contents, one cycle behind the inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_c  <= 1'b0;
      exp_ct <= '0;
    end else begin
      exp_c  <= a & b;
      exp_ct <= ref_taint(a, a_t, b, b_t);
    end
  end

  always @(negedge clk) begin
    if (model_on) chk("model", {c, c_t}, {exp_c, exp_ct});
  end

  task automatic drive_check(logic ia, logic ib, logic [31:0] iat, logic [31:0] ibt,
                             logic ec, logic [31:0] ect, string name);
    a = ia; b = ib; a_t = iat; b_t = ibt;
    @(posedge clk);
    #1;
    chk(name, {c, c_t}, {ec, ect});
  endtask

  task automatic rand_inputs();
    int sel;
    a   = 1'($urandom);
    b   = 1'($urandom);
    sel = $urandom_range(0, 7);
    case (sel)
      0:       begin a_t = '0;           b_t = '0;           end
      1:       begin a_t = 32'hFFFF_FFFF; b_t = 32'hFFFF_FFFF; end
      2:       begin a_t = 32'h8000_0000; b_t = $urandom;      end
      default: begin a_t = $urandom;      b_t = $urandom;      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; a_t = 32'hFFFF_FFFF; b_t = 32'hFFFF_FFFF;

    // Reset before any clock edge, then held across edges.
    #2;
    chk("reset_no_edge", {c, c_t}, 33'h0);
    @(negedge clk);
    chk("reset_hold1", {c, c_t}, 33'h0);
    @(negedge clk);
    chk("reset_hold2", {c, c_t}, 33'h0);
    #1 rst_n = 1'b1;
    model_on = 1'b1;

    // Pin the model itself against hand-computed values.
    chk("model_mask",  {1'b0, ref_taint(1'b0, 32'h0, 1'b1, 32'hF0)}, {1'b0, 32'h0});
    chk("model_pass",  {1'b0, ref_taint(1'b1, 32'h0, 1'b1, 32'hF0)}, {1'b0, 32'hF0});
    chk("model_both0", {1'b0, ref_taint(1'b0, 32'hF, 1'b0, 32'h3)}, {1'b0, 32'h3});

    @(posedge clk); #1;
    drive_check(0, 0, 0, 0, 0, 32'h0, "tt00");
    drive_check(0, 1, 0, 0, 0, 32'h0, "tt01");
    drive_check(1, 0, 0, 0, 0, 32'h0, "tt10");
    drive_check(1, 1, 0, 0, 1, 32'h0, "tt11");
    drive_check(1, 0, 0, 0, 0, 32'h0, "tt10b");
    drive_check(0, 1, 0, 0, 0, 32'h0, "tt01b");

    drive_check(0, 1, 0, 32'h0000_00F0, 0, 32'h0, "mask_a0");
    drive_check(1, 1, 0, 32'h0000_00F0, 1, 32'h0000_00F0, "mask_a1");
    drive_check(0, 0, 32'h0000_000F, 32'h0000_0003, 0, 32'h0000_0003, "both_zero");
    drive_check(1, 1, 32'h0000_000F, 32'h0000_0003, 1, 32'h0000_000F, "both_one");
    drive_check(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, "all_ones");
    drive_check(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, "msb_masked");
    drive_check(0, 1, 32'h8000_0000, 32'h0, 0, 32'h8000_0000, "msb_pass");
    drive_check(1, 1, 32'h1234_5678, 32'h8765_4321, 1, 32'h9775_5779, "no_taint_drop");

    // Load a non-zero state, then pulse reset between edges.
    a = 1; b = 1; a_t = 32'hFFFF_FFFF; b_t = 32'h0;
    @(posedge clk); #1;
    chk("pre_reset", {c, c_t}, {1'b1, 32'hFFFF_FFFF});

    for (int i = 0; i < 1000; i++) begin
      rand_inputs();
      if (i == 300 || i == 700) begin
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset", {c, c_t}, 33'h0);
        #3 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    @(negedge clk);
    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
